// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: scan FSM states,
// BCD nibble geometry and a helper that flags non-decimal digit codes.
package seven_seg_pkg;

  localparam int unsigned     BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  // A nibble above 9 cannot be shown as a decimal digit.
  function automatic logic bcd_invalid(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and flags the last cycle of
// each slot so the scan controller can advance to the next digit.
module scan_tick_gen #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] count_o,
  output logic          slot_end_o
);

  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: wrap to zero at the last cycle of the slot.
  always_comb begin
    count_d = count_q;
    if (count_q == LAST) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(1'b1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign slot_end_o = (count_q == LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Each digit slot opens with a
// dead time (all anodes off) to suppress ghosting, then shows one digit.
// New display values are double-buffered and only swapped in at frame end,
// so a frame never mixes two values. Outputs are registered and computed
// from the next-state values so they line up with the internal state.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEAD_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  input  logic [4*N_DIGITS-1:0]     load_data,
  output logic                      load_ready,
  input  logic                      lzb_en,
  input  logic                      blank_all,
  output logic [3:0]                bcd,
  output logic                      blank,
  output logic [N_DIGITS-1:0]       an_n,
  output logic                      frame_done,
  output logic                      bcd_err
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DW = BCD_W * N_DIGITS;

  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] PRE_END  = CW'(PRESCALE - 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  logic [CW-1:0] count_s;
  logic          slot_end_s;

  scan_tick_gen #(
    .PRESCALE (PRESCALE),
    .CW       (CW)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_o    (count_s),
    .slot_end_o (slot_end_s)
  );

  scan_state_e         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       active_q, active_d;
  logic [DW-1:0]       pending_q, pending_d;
  logic                pending_full_q, pending_full_d;

  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic                blank_q, blank_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                frame_done_q, frame_done_d;
  logic                bcd_err_q, bcd_err_d;

  logic                frame_end_s;
  logic                accept_s;
  logic [BCD_W-1:0]    nib_s;
  logic                lz_sel_s;
  logic                above_zero_s;

  assign frame_end_s = slot_end_s && (idx_q == LAST_IDX);
  assign accept_s    = load_valid && !pending_full_q;

  // Scan FSM: dead time at slot start, then show until the slot ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DEAD: begin
        if (count_s == DEAD_END) begin
          state_d = ST_SHOW;
        end else begin
          state_d = ST_DEAD;
        end
      end
      ST_SHOW: begin
        if (slot_end_s) begin
          state_d = ST_DEAD;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_DEAD;
    endcase
  end

  // Digit index steps once per slot and wraps after the last digit.
  always_comb begin
    idx_d = idx_q;
    if (slot_end_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1'b1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Double buffer: accept into pending, promote to active only at frame end.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    if (accept_s) begin
      pending_d      = load_data;
      pending_full_d = 1'b1;
    end else begin
      pending_d      = pending_q;
    end
    if (frame_end_s && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end else begin
      active_d       = active_q;
    end
  end

  // Select the current digit nibble and whether it and all higher digits are zero.
  always_comb begin
    nib_s        = {BCD_W{1'b0}};
    lz_sel_s     = 1'b0;
    above_zero_s = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      above_zero_s = above_zero_s && (active_q[i*BCD_W +: BCD_W] == 4'd0);
      if (IW'(i) == idx_q) begin
        nib_s    = active_q[i*BCD_W +: BCD_W];
        lz_sel_s = above_zero_s;
      end else begin
        nib_s    = nib_s;
      end
    end
  end

  // Display outputs for the upcoming cycle, driven from the next scan state.
  always_comb begin
    an_n_d    = {N_DIGITS{1'b1}};
    blank_d   = 1'b1;
    bcd_d     = {BCD_W{1'b0}};
    bcd_err_d = bcd_err_q;
    if (state_d == ST_SHOW) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        an_n_d[i] = (IW'(i) != idx_q);
      end
      bcd_d     = nib_s;
      blank_d   = blank_all || bcd_invalid(nib_s) ||
                  (lzb_en && (idx_q != {IW{1'b0}}) && lz_sel_s);
      bcd_err_d = bcd_err_q || bcd_invalid(nib_s);
    end else begin
      an_n_d    = {N_DIGITS{1'b1}};
      blank_d   = 1'b1;
      bcd_d     = {BCD_W{1'b0}};
      bcd_err_d = bcd_err_q;
    end
    frame_done_d = (count_s == PRE_END) && (idx_q == LAST_IDX);
  end

  // Scan state, digit index and display buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_DEAD;
      idx_q          <= {IW{1'b0}};
      active_q       <= {DW{1'b0}};
      pending_q      <= {DW{1'b0}};
      pending_full_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
    end
  end

  // Registered display outputs and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q       <= {N_DIGITS{1'b1}};
      blank_q      <= 1'b1;
      bcd_q        <= {BCD_W{1'b0}};
      frame_done_q <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      an_n_q       <= an_n_d;
      blank_q      <= blank_d;
      bcd_q        <= bcd_d;
      frame_done_q <= frame_done_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

  assign load_ready = !pending_full_q;
  assign an_n       = an_n_q;
  assign blank      = blank_q;
  assign bcd        = bcd_q;
  assign frame_done = frame_done_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_DIGITS, 4, number of multiplexed digits (2..8).
  PRESCALE, 50000, clock cycles per digit slot (>= DEAD_CYCLES+2).
  DEAD_CYCLES, 64, cycles at slot start with all anodes off (ghost suppression, >= 1).
REQ-002 The design SHALL use one clock; reset SHALL be asynchronous and active-low. Ports SHALL be, one per line: name direction width meaning.
  clk  input  1  system clock, rising edge.
  rst_n  input  1  asynchronous active-low reset.
  load_valid  input  1  new display value offered.
  load_data  input  4*N_DIGITS  packed BCD; nibble i is digit i; digit 0 least significant.
  load_ready  output  1  pending buffer empty, offer accepted.
  lzb_en  input  1  leading-zero blanking enable.
  blank_all  input  1  force all digits blank.
  bcd  output  4  digit code to seven_seg_decoder.
  blank  output  1  blank request to seven_seg_decoder.
  an_n  output  N_DIGITS  active-low digit anode enables.
  frame_done  output  1  one-cycle pulse at end of last digit slot.
  bcd_err  output  1  sticky flag: a displayed nibble exceeded 9.

Function
REQ-003 Prescaler SHALL count 0..PRESCALE-1 and wrap; slot end is count==PRESCALE-1.
REQ-004 Digit index SHALL advance 0,1,..,N_DIGITS-1,0 at each slot end.
REQ-005 FSM SHALL have states DEAD and SHOW; DEAD for counts 0..DEAD_CYCLES-1, SHOW for the remainder of the slot; DEAD->SHOW at count==DEAD_CYCLES-1, SHOW->DEAD at slot end.
REQ-006 In DEAD: an_n all ones, blank=1, bcd=0.
REQ-007 In SHOW: an_n has only bit [digit index] low; bcd = active-register nibble of that digit; all outputs registered.
REQ-008 blank SHALL be 1 in SHOW when blank_all=1, or when the nibble is >9, or when lzb_en=1, the digit index >0 and that nibble and every higher nibble are zero; digit 0 is never zero-blanked.
REQ-009 bcd_err SHALL set on the first SHOW cycle of any nibble >9 and SHALL hold until reset.
REQ-010 load_ready SHALL equal NOT pending_full; a transfer occurs when load_valid && load_ready; data goes to the pending register and sets pending_full.
REQ-011 At frame end (slot end of digit N_DIGITS-1), if pending_full, pending SHALL copy to the active register and pending_full SHALL clear; the new value is displayed from the next slot (digit 0). frame_done SHALL pulse in that same cycle.
REQ-012 If a load is accepted in the frame-end cycle with pending empty, the value SHALL enter pending and take effect at the following frame end, never mid-frame.
REQ-013 The active register SHALL never change except at frame end; one frame always shows one consistent value.
REQ-014 blank_all and lzb_en SHALL be sampled each cycle, with no effect on timing.

Reset
REQ-015 While rst_n=0: prescaler=0, digit index=0, state=DEAD, active=0, pending_full=0, load_ready=1 (after release), an_n all ones, blank=1, bcd=0, frame_done=0, bcd_err=0.
REQ-016 Reset assertion mid-slot or mid-load SHALL take effect immediately; pending data is discarded.

Structure
REQ-017 Shared package seven_seg_pkg SHALL hold the FSM state enum (DEAD, SHOW), the BCD nibble width (4) and the BCD max value (9).
REQ-018 One sub-module SHALL exist: scan_tick_gen (prescaler producing the count and the slot-end strobe); downstream seven_seg_decoder is connected at top level, not inside this block.

Verification (N_DIGITS=4, PRESCALE=8, DEAD_CYCLES=2)
REQ-019 Reset release, no load -> an_n cycles 1110,1101,1011,0111 each low for 6 of 8 cycles; frame_done every 32 cycles; bcd=0; blank=0 only on digit 0 when lzb_en=1.
REQ-020 Load 0x1234 mid-frame -> load_ready drops next cycle; digits show 4,3,2,1 from the slot after the next frame_done; load_ready returns 1 that cycle.
REQ-021 Load 0x0050 with lzb_en=1 -> digits 3 and 2 blank=1; digit 1 bcd=5, blank=0; digit 0 bcd=0, blank=0.
REQ-022 Load 0x00A1 -> digit 1 blank=1; bcd_err=1 from its first SHOW cycle and stays 1 through a later load of 0x0000.
REQ-023 Second load offered while pending full -> held off (load_ready=0); load accepted in the frame_done cycle -> displayed only after the next frame_done.
REQ-024 rst_n pulsed low during SHOW of digit 2 -> an_n=1111, blank=1 immediately; after release the scan restarts at digit 0 in DEAD with active value 0.
